// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sc_pkg
// Purpose : Shared sizing and FSM state encoding for the SC frame scheduler.
// Revision: 1.0
// ============================================================================
package sc_pkg;

    localparam int N         = 12;
    localparam int FRAME_LEN = 2 ** N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sc_skid_reg.sv
`default_nettype none
// ============================================================================
// Module  : sc_skid_reg
// Purpose : One-entry valid/ready holding register; accepts only when empty.
// Revision: 1.0
// ============================================================================
module sc_skid_reg #(
    parameter int W = 13
) (
    input  logic         clock_d,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         vld_q;
    logic         vld_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Push and pop are mutually exclusive: push needs empty, pop needs full.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (in_valid && !vld_q) begin
            vld_d  = 1'b1;
            data_d = in_data;
        end else if (pop) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clock_d or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign in_ready  = !vld_q;
    assign out_valid = vld_q;
    assign out_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/sc_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : sc_frame_sched
// Purpose : Frames one buffered sample per FRAME_LEN cycles into an SC
//           datapath and captures its result with output backpressure.
// Revision: 1.0
// ============================================================================
module sc_frame_sched #(
    parameter int N         = sc_pkg::N,
    parameter int FRAME_LEN = sc_pkg::FRAME_LEN
) (
    input  logic         clock_d,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N:0]   in_data,
    output logic [N:0]   hwa_in,
    output logic         hwa_sample,
    output logic [N-1:0] bit_idx,
    input  logic [N:0]   hwa_out,
    input  logic         hwa_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_data,
    output logic         busy,
    output logic         err_nodone
);

    import sc_pkg::*;

    localparam logic [N-1:0] LAST_IDX = N'(FRAME_LEN - 1);

    logic         ibuf_vld;
    logic [N:0]   ibuf_data;
    logic         ibuf_pop;

    state_t       state_q;
    state_t       state_d;
    logic [N-1:0] bit_idx_q;
    logic [N-1:0] bit_idx_d;
    logic [N:0]   hwa_in_q;
    logic [N:0]   hwa_in_d;
    logic         hwa_sample_q;
    logic         hwa_sample_d;
    logic         out_valid_q;
    logic         out_valid_d;
    logic [N:0]   out_data_q;
    logic [N:0]   out_data_d;
    logic         err_nodone_q;
    logic         err_nodone_d;

    logic         final_cyc;
    logic         slot_free;
    logic         capture;
    logic         start_frame;

    sc_skid_reg #(
        .W (N + 1)
    ) u_ibuf (
        .clock_d   (clock_d),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pop       (ibuf_pop),
        .out_valid (ibuf_vld),
        .out_data  (ibuf_data)
    );

    // STALL is only entered with an occupied output slot, so it is always a
    // final cycle waiting for out_ready.
    assign final_cyc = ((state_q == RUN) && (bit_idx_q == LAST_IDX)) || (state_q == STALL);
    assign slot_free = !out_valid_q || out_ready;
    assign capture   = final_cyc && slot_free;

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        hwa_in_d     = hwa_in_q;
        hwa_sample_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        err_nodone_d = err_nodone_q;
        start_frame  = 1'b0;

        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = hwa_out;
            if (!hwa_done) begin
                err_nodone_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                start_frame = ibuf_vld;
            end
            RUN: begin
                if (bit_idx_q != LAST_IDX) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end else if (slot_free) begin
                    start_frame = ibuf_vld;
                    state_d     = IDLE;
                end else begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (capture) begin
                    start_frame = ibuf_vld;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new frame overrides the IDLE fall-through chosen above.
        if (start_frame) begin
            state_d      = RUN;
            hwa_in_d     = ibuf_data;
            bit_idx_d    = '0;
            hwa_sample_d = 1'b1;
        end
    end

    assign ibuf_pop = start_frame;

    always_ff @(posedge clock_d or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            hwa_in_q     <= '0;
            hwa_sample_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            err_nodone_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            hwa_in_q     <= hwa_in_d;
            hwa_sample_q <= hwa_sample_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            err_nodone_q <= err_nodone_d;
        end
    end

    assign hwa_in     = hwa_in_q;
    assign hwa_sample = hwa_sample_q;
    assign bit_idx    = bit_idx_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign err_nodone = err_nodone_q;
    assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sc_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sc_frame_sched
// Purpose : Randomised and directed bench for sc_frame_sched against a
//           frame-timing reference model. Revision: 1.0
// ============================================================================
module tb_sc_frame_sched;

    localparam int N  = 12;
    localparam int FL = 4096;

    logic         clock_d = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [N:0]   in_data;
    logic [N:0]   hwa_in;
    logic         hwa_sample;
    logic [N-1:0] bit_idx;
    logic [N:0]   hwa_out;
    logic         hwa_done;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out_data;
    logic         busy;
    logic         err_nodone;

    int total = 0;
    int bad   = 0;

    sc_frame_sched #(.N(N), .FRAME_LEN(FL)) dut (
        .clock_d    (clock_d),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .hwa_in     (hwa_in),
        .hwa_sample (hwa_sample),
        .bit_idx    (bit_idx),
        .hwa_out    (hwa_out),
        .hwa_done   (hwa_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .err_nodone (err_nodone)
    );

    always #5 clock_d = ~clock_d;

    // Reference model: a frame is "started at cycle m_start"; its age gives
    // bit_idx, and it ends once age reaches FL-1 and the output slot frees.
    logic [N:0] m_q[$];
    logic       m_active;
    int         m_start;
    int         m_cyc;
    logic [N:0] m_in;
    logic       m_ov;
    logic [N:0] m_od;
    logic       m_err;
    logic       mdl_empty;
    logic       mdl_cap;
    int         mdl_age;

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_start  = 0;
        m_cyc    = 0;
        m_in     = '0;
        m_ov     = 1'b0;
        m_od     = '0;
        m_err    = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock_d or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                mdl_empty = (m_q.size() == 0);
                mdl_age   = m_cyc - m_start;
                mdl_cap   = m_active && (mdl_age >= FL - 1) && (!m_ov || out_ready);
                if (mdl_cap) begin
                    m_ov = 1'b1;
                    m_od = hwa_out;
                    if (!hwa_done) m_err = 1'b1;
                end else if (m_ov && out_ready) begin
                    m_ov = 1'b0;
                end
                if ((!m_active || mdl_cap) && m_q.size() > 0) begin
                    m_in     = m_q.pop_front();
                    m_active = 1'b1;
                    m_start  = m_cyc + 1;
                end else if (mdl_cap) begin
                    m_active = 1'b0;
                end
                if (in_valid && mdl_empty) m_q.push_back(in_data);
                m_cyc++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    logic [42:0]  cmp_act;
    logic [42:0]  cmp_exp;
    logic [N-1:0] exp_bit;
    int           exp_age;

    initial begin
        forever begin
            @(negedge clock_d);
            if (reset_n) begin
                exp_age = m_cyc - m_start;
                exp_bit = m_active ? N'((exp_age > FL - 1) ? FL - 1 : exp_age) : {N{1'b0}};
                cmp_exp = {m_active, m_active && (m_cyc == m_start), m_q.size() == 0,
                           m_ov, m_err, exp_bit, m_in, m_ov ? m_od : {(N+1){1'b0}}};
                cmp_act = {busy, hwa_sample, in_ready, out_valid, err_nodone,
                           m_active ? bit_idx : {N{1'b0}}, hwa_in,
                           m_ov ? out_data : {(N+1){1'b0}}};
                total++;
                if (cmp_act !== cmp_exp) begin
                    bad++;
                    $display("FAIL cycle %0d outputs: got %h want %h", m_cyc, cmp_act, cmp_exp);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Stimulus driver: feed[] holds samples still to be offered upstream.
    logic [N:0] feed[$];
    logic       rdy_seen;
    logic       rnd_in, rnd_ready, rnd_done, force_nodone;
    int         tcyc;

    task automatic step();
        logic acc;
        acc = in_valid && rdy_seen;
        @(negedge clock_d);
        if (acc && feed.size() > 0) void'(feed.pop_front());
        rdy_seen = in_ready;
        in_valid = (feed.size() > 0) && (!rnd_in || $urandom_range(0, 2) != 0);
        in_data  = (feed.size() > 0) ? feed[0] : (N+1)'($urandom);
        hwa_out  = (N+1)'($urandom);
        hwa_done = force_nodone ? 1'b0 : (rnd_done ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (rnd_ready) out_ready = ($urandom_range(0, 1) != 0);
        tcyc++;
    endtask

    task automatic wait_bit(input int idx, input int budget, input string name);
        int n;
        n = 0;
        while (!(busy && bit_idx == N'(idx)) && n < budget) begin
            step();
            n++;
        end
        lit(name, {31'd0, busy && bit_idx == N'(idx)}, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((busy || out_valid || feed.size() > 0) && n < budget) begin
            step();
            n++;
        end
        lit(name, {30'd0, busy, out_valid}, 32'd0);
    endtask

    logic [N:0] fin;
    int         pulses[$];

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; hwa_out = '0; hwa_done = 1'b1; out_ready = 1'b1;
        rnd_in = 1'b0; rnd_ready = 1'b0; rnd_done = 1'b0; force_nodone = 1'b0;
        rdy_seen = 1'b1; tcyc = 0;
        repeat (3) @(negedge clock_d);
        lit("rst_in_ready", {31'd0, in_ready}, 32'd1);
        lit("rst_busy", {31'd0, busy}, 32'd0);
        lit("rst_out_valid", {31'd0, out_valid}, 32'd0);
        #2 reset_n = 1'b1;

        // Single sample: accept, strobe one cycle later, result FL cycles after that.
        feed.push_back(13'h003);
        step(); step();
        lit("a_in_ready_full", {31'd0, in_ready}, 32'd0);
        lit("a_no_sample_yet", {31'd0, hwa_sample}, 32'd0);
        step();
        lit("a_sample", {31'd0, hwa_sample}, 32'd1);
        lit("a_hwa_in", {19'd0, hwa_in}, 32'h003);
        lit("a_bit0", {20'd0, bit_idx}, 32'd0);
        repeat (FL - 1) step();
        lit("a_bit_last", {20'd0, bit_idx}, FL - 1);
        lit("a_ov_before", {31'd0, out_valid}, 32'd0);
        fin = hwa_out;
        step();
        lit("a_ov_after", {31'd0, out_valid}, 32'd1);
        lit("a_out_data", {19'd0, out_data}, {19'd0, fin});
        lit("a_idle", {31'd0, busy}, 32'd0);

        // Streaming: three samples, frames back to back.
        feed.push_back(13'h003); feed.push_back(13'h007); feed.push_back(13'h00B);
        for (int i = 0; i < 3 * FL + 200 && pulses.size() < 3; i++) begin
            step();
            if (hwa_sample) pulses.push_back(tcyc);
        end
        wait_idle(FL + 100, "b_idle");
        lit("b_pulses", pulses.size(), 32'd3);
        for (int i = 1; i < pulses.size(); i++)
            lit("b_gap", pulses[i] - pulses[i-1], FL);

        // Full input buffer, missing done, backpressure stall.
        out_ready = 1'b0;
        force_nodone = 1'b1;
        feed.push_back(13'h011); feed.push_back(13'h022); feed.push_back(13'h033);
        repeat (4) step();
        lit("c_in_ready_full", {31'd0, in_ready}, 32'd0);
        repeat (10) step();
        lit("c_held", feed.size(), 32'd1);
        wait_bit(FL - 1, FL + 10, "c_f1_end");
        step();
        force_nodone = 1'b0;
        lit("c_err_set", {31'd0, err_nodone}, 32'd1);
        lit("c_f2_start", {31'd0, hwa_sample}, 32'd1);
        wait_bit(FL - 1, FL + 10, "c_f2_end");
        repeat (6) step();
        lit("c_stall_bit", {20'd0, bit_idx}, FL - 1);
        lit("c_stall_busy", {31'd0, busy}, 32'd1);
        lit("c_stall_nosample", {31'd0, hwa_sample}, 32'd0);
        out_ready = 1'b1;
        fin = hwa_out;
        step();
        lit("c_cap_data", {19'd0, out_data}, {19'd0, fin});
        lit("c_next_sample", {31'd0, hwa_sample}, 32'd1);
        lit("c_next_hwa_in", {19'd0, hwa_in}, 32'h033);
        wait_idle(FL + 100, "c_idle");
        lit("c_err_sticky", {31'd0, err_nodone}, 32'd1);

        // Randomised traffic, backpressure and done.
        rnd_in = 1'b1; rnd_ready = 1'b1; rnd_done = 1'b1;
        for (int i = 0; i < 6; i++) feed.push_back(13'($urandom_range(0, FL)));
        wait_idle(10 * FL, "r_idle");
        rnd_in = 1'b0; rnd_ready = 1'b0; rnd_done = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        // Reset in mid-frame with one sample still buffered.
        feed.push_back(13'h055); feed.push_back(13'h066);
        wait_bit(2000, 2 * FL, "d_reach");
        #2 reset_n = 1'b0;
        feed.delete();
        in_valid = 1'b0;
        #1;
        lit("d_in_ready", {31'd0, in_ready}, 32'd1);
        lit("d_busy", {31'd0, busy}, 32'd0);
        lit("d_sample", {31'd0, hwa_sample}, 32'd0);
        lit("d_bit", {20'd0, bit_idx}, 32'd0);
        lit("d_hwa_in", {19'd0, hwa_in}, 32'd0);
        lit("d_out_valid", {31'd0, out_valid}, 32'd0);
        lit("d_out_data", {19'd0, out_data}, 32'd0);
        lit("d_err", {31'd0, err_nodone}, 32'd0);
        @(negedge clock_d);
        @(negedge clock_d);
        #2 reset_n = 1'b1;
        rdy_seen = 1'b1;
        repeat (300) step();
        lit("d_no_result", {31'd0, out_valid}, 32'd0);
        lit("d_stay_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
